// File: rtl/riscv_mtimer_pkg.sv
// Shared definitions for the memory-mapped machine timer: address map,
// decoded register selector, bus request/response records and the
// byte-enable merge helper used by every writable register.
package riscv_mtimer_pkg;

    localparam logic [31:0] MTIME_MEM_ADDRESS_LOW     = 32'h0000_8004;
    localparam logic [31:0] MTIME_MEM_ADDRESS_HIGH    = 32'h0000_8008;
    localparam logic [31:0] MTIMECMP_MEM_ADDRESS_LOW  = 32'h0000_800C;
    localparam logic [31:0] MTIMECMP_MEM_ADDRESS_HIGH = 32'h0000_8010;

    localparam int unsigned MTIMER_PRESCALE_DEFAULT = 1;

    typedef enum logic [1:0] {
        MTIME_LOW     = 2'd0,
        MTIME_HIGH    = 2'd1,
        MTIMECMP_LOW  = 2'd2,
        MTIMECMP_HIGH = 2'd3
    } mtime_address_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mtimer_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mtimer_rsp_t;

    // Replace only the bytes whose enable is set; the rest keep old_val.
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/riscv_mtimer_prescaler.sv
// Tick generator for mtime: counts 0..PRESCALE-1 and asserts tick on the
// last count, then wraps. PRESCALE=1 yields a tick on every clock.
module riscv_mtimer_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    // A 1-bit counter is kept even for PRESCALE=1 so the width never collapses to 0.
    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    // Free-running prescale counter, wrapping on the tick cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/riscv_mtimer.sv
// Machine timer bus responder: holds mtime/mtimecmp, answers word-sized
// loads/stores with a fixed one-cycle response, and drives mtip_o.
// Optional build macro RISCV_MTIMER_SHADOW_READ_EN: a read of the mtime low
// word latches the high word so a following high-word read is carry-atomic.
module riscv_mtimer
    import riscv_mtimer_pkg::*;
#(
    parameter int unsigned PRESCALE  = MTIMER_PRESCALE_DEFAULT,
    parameter logic [31:0] BASE_ADDR = MTIME_MEM_ADDRESS_LOW
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mtip_o,
    output logic [63:0] mtime_o
);

    logic           tick;
    logic [63:0]    mtime;
    logic [63:0]    mtimecmp;
    mtimer_req_t    req;
    mtimer_rsp_t    rsp_d;
    logic           accept;
    logic [31:0]    offset;
    logic           addr_hit;
    mtime_address_t addr_sel;
    logic           wr_hit;
    logic           rd_hit;
    logic           wr_mtime_lo;
    logic           wr_mtime_hi;
    logic           wr_cmp_lo;
    logic           wr_cmp_hi;
    logic [31:0]    mtime_hi_rd;

    riscv_mtimer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign req     = {req_we, req_addr, req_wdata, req_be};
    assign accept  = req_valid && req_ready;
    assign mtime_o = mtime;

    // Address decode: only the four aligned words of the window are mapped.
    always_comb begin
        offset   = req.addr - BASE_ADDR;
        addr_hit = (offset[31:4] == 28'd0) && (offset[1:0] == 2'b00)
                   && (req.addr[1:0] == 2'b00);
        addr_sel = mtime_address_t'(offset[3:2]);
        wr_hit   = accept && req.we && addr_hit;
        rd_hit   = accept && !req.we && addr_hit;
        wr_mtime_lo = wr_hit && (addr_sel == MTIME_LOW);
        wr_mtime_hi = wr_hit && (addr_sel == MTIME_HIGH);
        wr_cmp_lo   = wr_hit && (addr_sel == MTIMECMP_LOW);
        wr_cmp_hi   = wr_hit && (addr_sel == MTIMECMP_HIGH);
    end

`ifdef RISCV_MTIMER_SHADOW_READ_EN
    logic [31:0] shadow_hi;
    logic        shadow_vld;
    logic        rd_mtime_lo;

    assign rd_mtime_lo = rd_hit && (addr_sel == MTIME_LOW);
    assign mtime_hi_rd = shadow_vld ? shadow_hi : mtime[63:32];

    // Latch the pre-update high word on a low-word read; any mtime write invalidates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_hi  <= '0;
            shadow_vld <= 1'b0;
        end else if (rd_mtime_lo) begin
            shadow_hi  <= mtime[63:32];
            shadow_vld <= 1'b1;
        end else if (wr_mtime_lo || wr_mtime_hi) begin
            shadow_vld <= 1'b0;
        end
    end
`else
    assign mtime_hi_rd = mtime[63:32];
`endif

    // Read mux over pre-update register values; writes and errors return 0.
    always_comb begin
        rsp_d.rdata = '0;
        rsp_d.err   = accept && !addr_hit;
        if (rd_hit) begin
            case (addr_sel)
                MTIME_LOW:     rsp_d.rdata = mtime[31:0];
                MTIME_HIGH:    rsp_d.rdata = mtime_hi_rd;
                MTIMECMP_LOW:  rsp_d.rdata = mtimecmp[31:0];
                MTIMECMP_HIGH: rsp_d.rdata = mtimecmp[63:32];
            endcase
        end
    end

    // Bus side: ready after reset, one-cycle response strobe with registered data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            req_ready <= 1'b1;
            rsp_valid <= accept;
            rsp_rdata <= rsp_d.rdata;
            rsp_err   <= rsp_d.err;
        end
    end

    // mtime: a bus write to either half wins over the tick for that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime <= '0;
        end else if (wr_mtime_lo) begin
            mtime[31:0] <= be_merge(mtime[31:0], req.wdata, req.be);
        end else if (wr_mtime_hi) begin
            mtime[63:32] <= be_merge(mtime[63:32], req.wdata, req.be);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // mtimecmp: byte-merged writes, resets to all-ones so mtip stays low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtimecmp <= '1;
        end else if (wr_cmp_lo) begin
            mtimecmp[31:0] <= be_merge(mtimecmp[31:0], req.wdata, req.be);
        end else if (wr_cmp_hi) begin
            mtimecmp[63:32] <= be_merge(mtimecmp[63:32], req.wdata, req.be);
        end
    end

    // Level interrupt from the registered compare; lags register changes by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtip_o <= 1'b0;
        end else begin
            mtip_o <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_riscv_mtimer.sv
// Directed bench for riscv_mtimer (PRESCALE=1). Inputs change on the falling
// edge; outputs are sampled 1 time unit after the rising edge or on the
// falling edge. With PRESCALE=1 mtime advances on every rising edge unless
// that edge carries an mtime write.
module tb_riscv_mtimer;
    import riscv_mtimer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mtip_o;
    logic [63:0] mtime_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] rdata;
    logic        err;

    riscv_mtimer #(
        .PRESCALE  (1),
        .BASE_ADDR (32'h0000_8004)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mtip_o    (mtip_o),
        .mtime_o   (mtime_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One bus transaction; called with clk low, returns at the next falling edge.
    task automatic bus_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rd, output logic er);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = 4'h0;
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge clk);
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be);
        logic [31:0] r;
        logic        e;
        bus_op(1'b1, addr, wdata, be, r, e);
        check({tag, "_err"}, 64'(e), 64'd0);
        check({tag, "_rdata"}, 64'(r), 64'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        logic        e;
        bus_op(1'b0, addr, 32'h0, 4'h0, r, e);
        check({tag, "_err"}, 64'(e), 64'd0);
        check(tag, 64'(r), 64'(exp));
    endtask

    task automatic err_chk(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
        logic [31:0] r;
        logic        e;
        bus_op(we, addr, wdata, 4'hF, r, e);
        check({tag, "_err"}, 64'(e), 64'd1);
        check({tag, "_rdata"}, 64'(r), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #2;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_mtip", 64'(mtip_o), 64'd0);
        check("rst_mtime", mtime_o, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle 10 edges after release: ready after the first, mtime = 10
        @(negedge clk);
        check("ready_up", 64'(req_ready), 64'd1);
        repeat (9) @(negedge clk);
        check("idle_mtime", mtime_o, 64'd10);
        rd_chk("idle_rd_lo", MTIME_MEM_ADDRESS_LOW, 32'd10);
        check("idle_mtip", 64'(mtip_o), 64'd0);
        @(posedge clk);
        #1;
        check("rsp_one_cycle", 64'(rsp_valid), 64'd0);
        @(negedge clk);

        // Byte-enable merge on mtimecmp and be=0 no-op
        wr("cmp_be", MTIMECMP_MEM_ADDRESS_LOW, 32'hAABB_CCDD, 4'b0010);
        rd_chk("cmp_lo_merged", MTIMECMP_MEM_ADDRESS_LOW, 32'hFFFF_CCFF);
        wr("cmp_be0", MTIMECMP_MEM_ADDRESS_HIGH, 32'h0000_0000, 4'b0000);
        rd_chk("cmp_hi_be0", MTIMECMP_MEM_ADDRESS_HIGH, 32'hFFFF_FFFF);

        // Unmapped / misaligned accesses, with no side effects
        err_chk("rd_8014", 1'b0, 32'h0000_8014, 32'h0);
        err_chk("rd_8006", 1'b0, 32'h0000_8006, 32'h0);
        err_chk("rd_8000", 1'b0, 32'h0000_8000, 32'h0);
        err_chk("wr_800d", 1'b1, 32'h0000_800D, 32'h0);
        err_chk("wr_8014", 1'b1, 32'h0000_8014, 32'h0);
        rd_chk("cmp_lo_kept", MTIMECMP_MEM_ADDRESS_LOW, 32'hFFFF_CCFF);
        rd_chk("cmp_hi_kept", MTIMECMP_MEM_ADDRESS_HIGH, 32'hFFFF_FFFF);
        wr("mt_lo_100", MTIME_MEM_ADDRESS_LOW, 32'd100, 4'hF);
        check("mt_after_wr", mtime_o, 64'd100);
        err_chk("wr_8005", 1'b1, 32'h0000_8005, 32'hDEAD_BEEF);
        check("mt_after_errwr", mtime_o, 64'd101);

        // Carry from low to high word; writes drop the tick
        wr("mt_lo_ff", MTIME_MEM_ADDRESS_LOW, 32'hFFFF_FFFF, 4'hF);
        wr("mt_hi_0", MTIME_MEM_ADDRESS_HIGH, 32'h0, 4'hF);
        check("mt_pre_carry", mtime_o, 64'h0000_0000_FFFF_FFFF);
        @(negedge clk);
        check("mt_carry", mtime_o, 64'h0000_0001_0000_0000);
        rd_chk("carry_rd_hi", MTIME_MEM_ADDRESS_HIGH, 32'd1);
        rd_chk("carry_rd_lo", MTIME_MEM_ADDRESS_LOW, 32'd1);

        // 64-bit wrap; all-ones briefly exceeds mtimecmp so mtip pulses once
        wr("mt_hi_ff", MTIME_MEM_ADDRESS_HIGH, 32'hFFFF_FFFF, 4'hF);
        wr("mt_lo_ff2", MTIME_MEM_ADDRESS_LOW, 32'hFFFF_FFFF, 4'hF);
        check("mt_all_ones", mtime_o, 64'hFFFF_FFFF_FFFF_FFFF);
        check("mtip_before_wrap", 64'(mtip_o), 64'd0);
        @(negedge clk);
        check("mt_wrap", mtime_o, 64'd0);
        check("mtip_wrap_pulse", 64'(mtip_o), 64'd1);
        @(negedge clk);
        check("mt_after_wrap", mtime_o, 64'd1);
        check("mtip_wrap_clear", 64'(mtip_o), 64'd0);

        // Compare at 20: mtip rises one cycle after mtime reaches 20
        wr("cmp_lo_20", MTIMECMP_MEM_ADDRESS_LOW, 32'd20, 4'hF);
        wr("cmp_hi_0", MTIMECMP_MEM_ADDRESS_HIGH, 32'd0, 4'hF);
        wr("mt_lo_0", MTIME_MEM_ADDRESS_LOW, 32'd0, 4'hF);
        check("mt_zero", mtime_o, 64'd0);
        repeat (20) @(negedge clk);
        check("mt_at_20", mtime_o, 64'd20);
        check("mtip_at_20", 64'(mtip_o), 64'd0);
        @(negedge clk);
        check("mtip_rise", 64'(mtip_o), 64'd1);
        wr("cmp_lo_100", MTIMECMP_MEM_ADDRESS_LOW, 32'd100, 4'hF);
        check("mtip_hold", 64'(mtip_o), 64'd1);
        @(negedge clk);
        check("mtip_fall", 64'(mtip_o), 64'd0);

        // Low-then-high read pair across a carry
        wr("sh_hi_0", MTIME_MEM_ADDRESS_HIGH, 32'd0, 4'hF);
        wr("sh_lo_fe", MTIME_MEM_ADDRESS_LOW, 32'hFFFF_FFFE, 4'hF);
        rd_chk("sh_rd_lo", MTIME_MEM_ADDRESS_LOW, 32'hFFFF_FFFE);
        repeat (3) @(negedge clk);
        check("sh_mtime", mtime_o, 64'h0000_0001_0000_0002);
`ifdef RISCV_MTIMER_SHADOW_READ_EN
        rd_chk("sh_rd_hi", MTIME_MEM_ADDRESS_HIGH, 32'd0);
        rd_chk("sh_rd_hi2", MTIME_MEM_ADDRESS_HIGH, 32'd0);
`else
        rd_chk("sh_rd_hi", MTIME_MEM_ADDRESS_HIGH, 32'd1);
        rd_chk("sh_rd_hi2", MTIME_MEM_ADDRESS_HIGH, 32'd1);
`endif
        wr("sh_inval", MTIME_MEM_ADDRESS_LOW, 32'd5, 4'hF);
        rd_chk("sh_rd_hi_live", MTIME_MEM_ADDRESS_HIGH, 32'd1);

        // Reset while a response is on the bus
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = MTIMECMP_MEM_ADDRESS_LOW;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("mid_rsp_valid", 64'(rsp_valid), 64'd1);
        check("mid_rsp_rdata", 64'(rsp_rdata), 64'd100);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_rdata", 64'(rsp_rdata), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        check("mid_rst_mtime", mtime_o, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerst_ready", 64'(req_ready), 64'd1);
        check("rerst_mtime", mtime_o, 64'd1);
        rd_chk("rerst_cmp_lo", MTIMECMP_MEM_ADDRESS_LOW, 32'hFFFF_FFFF);
        rd_chk("rerst_cmp_hi", MTIMECMP_MEM_ADDRESS_HIGH, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
